// File: rtl/delay_pipeline_pkg.sv
// delay_pipeline_pkg: width helpers shared by the variable-depth delay pipeline
package delay_pipeline_pkg;
  function automatic int sel_w(input int max_depth);
    return $clog2(max_depth);
  endfunction
  function automatic int cnt_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one {valid, data} register of the delay pipeline
module delay_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end
endmodule

// File: rtl/delay_pipeline_var.sv
// delay_pipeline_var: valid-qualified delay line with runtime-selectable depth, stall and flush
module delay_pipeline_var
  import delay_pipeline_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_DEPTH = 8,
  parameter int SEL_W     = sel_w(MAX_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic [SEL_W-1:0]              delay_sel,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              data_out,
  output logic [cnt_w(MAX_DEPTH)-1:0]   in_flight
);
  localparam int CNT_W = cnt_w(MAX_DEPTH);
  logic [MAX_DEPTH-1:0]            v;
  logic [MAX_DEPTH-1:0][WIDTH-1:0] d;
  logic [MAX_DEPTH-1:0]            v_prev;
  logic [MAX_DEPTH-1:0][WIDTH-1:0] d_prev;
  logic [SEL_W-1:0]                sel_c;
  assign v_prev = {v[MAX_DEPTH-2:0], in_valid};
  assign d_prev = {d[MAX_DEPTH-2:0], data_in};
  for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_stage
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .prev_valid(v_prev[g]),
      .prev_data (d_prev[g]),
      .valid     (v[g]),
      .data      (d[g])
    );
  end
  // out-of-range selects only exist for non-power-of-2 depths
  assign sel_c     = (delay_sel > SEL_W'(MAX_DEPTH - 1)) ? SEL_W'(MAX_DEPTH - 1) : delay_sel;
  assign out_valid = v[sel_c];
  assign data_out  = out_valid ? d[sel_c] : '0;
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      in_flight = in_flight + ((SEL_W'(i) <= sel_c) ? CNT_W'(v[i]) : CNT_W'(0));
  end
endmodule
